// File: rtl/nn_stream_pkg.sv
// Shared constants, types and coefficient tables for the dense16 inference core.
// Coefficients are test defaults (identity weights, ramp bias); trained values replace them.
package nn_stream_pkg;
  localparam int N_IN  = 8;
  localparam int N_OUT = 16;
  localparam int DW    = 16;
  localparam int FRAC  = 10;
  localparam int ACC_W = 36;
  localparam int CNT_W = $clog2(N_IN);

  typedef logic signed [DW-1:0] fixed16_t;
  typedef logic [N_IN-1:0][N_OUT-1:0][DW-1:0] w_arr_t;
  typedef logic [N_OUT-1:0][DW-1:0] b_arr_t;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FINAL, S_OUT} state_t;

  function automatic w_arr_t gen_w();
    w_arr_t w;
    for (int i = 0; i < N_IN; i++)
      for (int k = 0; k < N_OUT; k++)
        w[i][k] = (i == k) ? DW'(1024) : '0;
    return w;
  endfunction

  function automatic b_arr_t gen_b();
    b_arr_t b;
    for (int k = 0; k < N_OUT; k++) b[k] = DW'(256 * k);
    return b;
  endfunction

  localparam w_arr_t W = gen_w();
  localparam b_arr_t B = gen_b();
endpackage

// File: rtl/nn_stream_dense16_lane.sv
// One output neuron: MAC into a Q16.20 accumulator, then bias, truncate/wrap to Q6.10 and ReLU.
// Holds its own output beat until that channel's handshake completes.
module nn_mac_lane import nn_stream_pkg::*; (
  input  logic     ap_clk,
  input  logic     ap_rst_n,
  input  logic     i_clr,
  input  logic     i_mac,
  input  logic     i_final,
  input  fixed16_t i_x,
  input  fixed16_t i_w,
  input  fixed16_t i_b,
  input  logic     i_tready,
  output fixed16_t o_tdata,
  output logic     o_tvalid
);
  logic signed [ACC_W-1:0] r_acc;
  logic signed [31:0]      w_prod;
  logic signed [ACC_W-1:0] w_sum;
  fixed16_t                w_trunc;
  fixed16_t                w_y;

  assign w_prod  = 32'(i_x) * 32'(i_w);
  // Bias is Q6.10; align to the accumulator's 20 fractional bits.
  assign w_sum   = r_acc + {{(ACC_W-DW-FRAC){i_b[DW-1]}}, i_b, {FRAC{1'b0}}};
  assign w_trunc = w_sum[DW+FRAC-1:FRAC];
  assign w_y     = w_trunc[DW-1] ? '0 : w_trunc;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_acc    <= '0;
      o_tdata  <= '0;
      o_tvalid <= 1'b0;
    end else begin
      if (i_clr)      r_acc <= '0;
      else if (i_mac) r_acc <= r_acc + ACC_W'(w_prod);
      if (i_final) begin
        o_tdata  <= w_y;
        o_tvalid <= 1'b1;
      end else if (o_tvalid && i_tready) begin
        o_tvalid <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/nn_stream_dense16.sv
// Streaming dense N_IN->16 layer with bias and ReLU behind ap_ctrl_hs control.
// One run at a time: IDLE -> LOAD (N_IN beats) -> FINAL -> OUT (16 independent channels).
module nn_stream_dense16 import nn_stream_pkg::*; (
  input  logic          ap_clk,
  input  logic          ap_rst_n,
  input  logic          ap_start,
  output logic          ap_done,
  output logic          ap_idle,
  output logic          ap_ready,
  input  logic [DW-1:0] input_1_V_data_0_V_TDATA,
  input  logic          input_1_V_data_0_V_TVALID,
  output logic          input_1_V_data_0_V_TREADY,
  output logic [DW-1:0] layer6_out_V_data_0_V_TDATA,  output logic layer6_out_V_data_0_V_TVALID,  input logic layer6_out_V_data_0_V_TREADY,
  output logic [DW-1:0] layer6_out_V_data_1_V_TDATA,  output logic layer6_out_V_data_1_V_TVALID,  input logic layer6_out_V_data_1_V_TREADY,
  output logic [DW-1:0] layer6_out_V_data_2_V_TDATA,  output logic layer6_out_V_data_2_V_TVALID,  input logic layer6_out_V_data_2_V_TREADY,
  output logic [DW-1:0] layer6_out_V_data_3_V_TDATA,  output logic layer6_out_V_data_3_V_TVALID,  input logic layer6_out_V_data_3_V_TREADY,
  output logic [DW-1:0] layer6_out_V_data_4_V_TDATA,  output logic layer6_out_V_data_4_V_TVALID,  input logic layer6_out_V_data_4_V_TREADY,
  output logic [DW-1:0] layer6_out_V_data_5_V_TDATA,  output logic layer6_out_V_data_5_V_TVALID,  input logic layer6_out_V_data_5_V_TREADY,
  output logic [DW-1:0] layer6_out_V_data_6_V_TDATA,  output logic layer6_out_V_data_6_V_TVALID,  input logic layer6_out_V_data_6_V_TREADY,
  output logic [DW-1:0] layer6_out_V_data_7_V_TDATA,  output logic layer6_out_V_data_7_V_TVALID,  input logic layer6_out_V_data_7_V_TREADY,
  output logic [DW-1:0] layer6_out_V_data_8_V_TDATA,  output logic layer6_out_V_data_8_V_TVALID,  input logic layer6_out_V_data_8_V_TREADY,
  output logic [DW-1:0] layer6_out_V_data_9_V_TDATA,  output logic layer6_out_V_data_9_V_TVALID,  input logic layer6_out_V_data_9_V_TREADY,
  output logic [DW-1:0] layer6_out_V_data_10_V_TDATA, output logic layer6_out_V_data_10_V_TVALID, input logic layer6_out_V_data_10_V_TREADY,
  output logic [DW-1:0] layer6_out_V_data_11_V_TDATA, output logic layer6_out_V_data_11_V_TVALID, input logic layer6_out_V_data_11_V_TREADY,
  output logic [DW-1:0] layer6_out_V_data_12_V_TDATA, output logic layer6_out_V_data_12_V_TVALID, input logic layer6_out_V_data_12_V_TREADY,
  output logic [DW-1:0] layer6_out_V_data_13_V_TDATA, output logic layer6_out_V_data_13_V_TVALID, input logic layer6_out_V_data_13_V_TREADY,
  output logic [DW-1:0] layer6_out_V_data_14_V_TDATA, output logic layer6_out_V_data_14_V_TVALID, input logic layer6_out_V_data_14_V_TREADY,
  output logic [DW-1:0] layer6_out_V_data_15_V_TDATA, output logic layer6_out_V_data_15_V_TVALID, input logic layer6_out_V_data_15_V_TREADY,
  output logic [15:0]   const_size_in_1,
  output logic          const_size_in_1_ap_vld,
  output logic [15:0]   const_size_out_1,
  output logic          const_size_out_1_ap_vld
);
  state_t             r_state, w_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ready, r_done, r_size_vld;
  logic               w_clr, w_mac, w_final, w_last_beat, w_done;
  fixed16_t           w_tdata  [N_OUT];
  logic [N_OUT-1:0]   w_tvalid, w_tready, w_ch_fin;

  assign w_tready = {layer6_out_V_data_15_V_TREADY, layer6_out_V_data_14_V_TREADY,
                     layer6_out_V_data_13_V_TREADY, layer6_out_V_data_12_V_TREADY,
                     layer6_out_V_data_11_V_TREADY, layer6_out_V_data_10_V_TREADY,
                     layer6_out_V_data_9_V_TREADY,  layer6_out_V_data_8_V_TREADY,
                     layer6_out_V_data_7_V_TREADY,  layer6_out_V_data_6_V_TREADY,
                     layer6_out_V_data_5_V_TREADY,  layer6_out_V_data_4_V_TREADY,
                     layer6_out_V_data_3_V_TREADY,  layer6_out_V_data_2_V_TREADY,
                     layer6_out_V_data_1_V_TREADY,  layer6_out_V_data_0_V_TREADY};
  // A channel is finished once its beat is gone or leaves this cycle.
  assign w_ch_fin = ~w_tvalid | w_tready;

  assign input_1_V_data_0_V_TREADY = (r_state == S_LOAD);
  assign ap_idle                   = (r_state == S_IDLE);
  assign ap_ready                  = r_ready;
  assign ap_done                   = r_done;
  assign const_size_in_1           = 16'(N_IN);
  assign const_size_out_1          = 16'(N_OUT);
  assign const_size_in_1_ap_vld    = r_size_vld;
  assign const_size_out_1_ap_vld   = r_size_vld;

  always_comb begin
    w_nxt       = r_state;
    w_clr       = 1'b0;
    w_mac       = 1'b0;
    w_final     = 1'b0;
    w_last_beat = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: if (ap_start) begin
        w_nxt = S_LOAD;
        w_clr = 1'b1;
      end
      S_LOAD: if (input_1_V_data_0_V_TVALID) begin
        w_mac = 1'b1;
        if (r_cnt == CNT_W'(N_IN-1)) begin
          w_last_beat = 1'b1;
          w_nxt       = S_FINAL;
        end
      end
      S_FINAL: begin
        w_final = 1'b1;
        w_nxt   = S_OUT;
      end
      S_OUT: if (&w_ch_fin) begin
        w_done = 1'b1;
        w_nxt  = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_ready    <= 1'b0;
      r_done     <= 1'b0;
      r_size_vld <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_ready    <= w_last_beat;
      r_done     <= w_done;
      r_size_vld <= w_clr;
      if (w_clr)      r_cnt <= '0;
      else if (w_mac) r_cnt <= r_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_lane
    nn_mac_lane u_lane (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .i_clr    (w_clr),
      .i_mac    (w_mac),
      .i_final  (w_final),
      .i_x      (input_1_V_data_0_V_TDATA),
      .i_w      (W[r_cnt][g]),
      .i_b      (B[g]),
      .i_tready (w_tready[g]),
      .o_tdata  (w_tdata[g]),
      .o_tvalid (w_tvalid[g])
    );
  end

  assign layer6_out_V_data_0_V_TDATA  = w_tdata[0];  assign layer6_out_V_data_0_V_TVALID  = w_tvalid[0];
  assign layer6_out_V_data_1_V_TDATA  = w_tdata[1];  assign layer6_out_V_data_1_V_TVALID  = w_tvalid[1];
  assign layer6_out_V_data_2_V_TDATA  = w_tdata[2];  assign layer6_out_V_data_2_V_TVALID  = w_tvalid[2];
  assign layer6_out_V_data_3_V_TDATA  = w_tdata[3];  assign layer6_out_V_data_3_V_TVALID  = w_tvalid[3];
  assign layer6_out_V_data_4_V_TDATA  = w_tdata[4];  assign layer6_out_V_data_4_V_TVALID  = w_tvalid[4];
  assign layer6_out_V_data_5_V_TDATA  = w_tdata[5];  assign layer6_out_V_data_5_V_TVALID  = w_tvalid[5];
  assign layer6_out_V_data_6_V_TDATA  = w_tdata[6];  assign layer6_out_V_data_6_V_TVALID  = w_tvalid[6];
  assign layer6_out_V_data_7_V_TDATA  = w_tdata[7];  assign layer6_out_V_data_7_V_TVALID  = w_tvalid[7];
  assign layer6_out_V_data_8_V_TDATA  = w_tdata[8];  assign layer6_out_V_data_8_V_TVALID  = w_tvalid[8];
  assign layer6_out_V_data_9_V_TDATA  = w_tdata[9];  assign layer6_out_V_data_9_V_TVALID  = w_tvalid[9];
  assign layer6_out_V_data_10_V_TDATA = w_tdata[10]; assign layer6_out_V_data_10_V_TVALID = w_tvalid[10];
  assign layer6_out_V_data_11_V_TDATA = w_tdata[11]; assign layer6_out_V_data_11_V_TVALID = w_tvalid[11];
  assign layer6_out_V_data_12_V_TDATA = w_tdata[12]; assign layer6_out_V_data_12_V_TVALID = w_tvalid[12];
  assign layer6_out_V_data_13_V_TDATA = w_tdata[13]; assign layer6_out_V_data_13_V_TVALID = w_tvalid[13];
  assign layer6_out_V_data_14_V_TDATA = w_tdata[14]; assign layer6_out_V_data_14_V_TVALID = w_tvalid[14];
  assign layer6_out_V_data_15_V_TDATA = w_tdata[15]; assign layer6_out_V_data_15_V_TVALID = w_tvalid[15];
endmodule

// File: tb/tb_nn_stream_dense16.sv
// Directed bench for nn_stream_dense16: control handshakes, per-channel outputs, wrap/ReLU and mid-run reset.
module tb_nn_stream_dense16;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        done, idle, ready;
  logic [15:0] in_d;
  logic        in_v, in_r;
  logic [15:0] od [16];
  logic        ov [16];
  logic [15:0] tr;
  logic [15:0] sz_in, sz_out;
  logic        sz_in_v, sz_out_v;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] last_y [16];

  always #5 clk = ~clk;

  nn_stream_dense16 dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start),
    .ap_done(done), .ap_idle(idle), .ap_ready(ready),
    .input_1_V_data_0_V_TDATA(in_d), .input_1_V_data_0_V_TVALID(in_v), .input_1_V_data_0_V_TREADY(in_r),
    .layer6_out_V_data_0_V_TDATA(od[0]),   .layer6_out_V_data_0_V_TVALID(ov[0]),   .layer6_out_V_data_0_V_TREADY(tr[0]),
    .layer6_out_V_data_1_V_TDATA(od[1]),   .layer6_out_V_data_1_V_TVALID(ov[1]),   .layer6_out_V_data_1_V_TREADY(tr[1]),
    .layer6_out_V_data_2_V_TDATA(od[2]),   .layer6_out_V_data_2_V_TVALID(ov[2]),   .layer6_out_V_data_2_V_TREADY(tr[2]),
    .layer6_out_V_data_3_V_TDATA(od[3]),   .layer6_out_V_data_3_V_TVALID(ov[3]),   .layer6_out_V_data_3_V_TREADY(tr[3]),
    .layer6_out_V_data_4_V_TDATA(od[4]),   .layer6_out_V_data_4_V_TVALID(ov[4]),   .layer6_out_V_data_4_V_TREADY(tr[4]),
    .layer6_out_V_data_5_V_TDATA(od[5]),   .layer6_out_V_data_5_V_TVALID(ov[5]),   .layer6_out_V_data_5_V_TREADY(tr[5]),
    .layer6_out_V_data_6_V_TDATA(od[6]),   .layer6_out_V_data_6_V_TVALID(ov[6]),   .layer6_out_V_data_6_V_TREADY(tr[6]),
    .layer6_out_V_data_7_V_TDATA(od[7]),   .layer6_out_V_data_7_V_TVALID(ov[7]),   .layer6_out_V_data_7_V_TREADY(tr[7]),
    .layer6_out_V_data_8_V_TDATA(od[8]),   .layer6_out_V_data_8_V_TVALID(ov[8]),   .layer6_out_V_data_8_V_TREADY(tr[8]),
    .layer6_out_V_data_9_V_TDATA(od[9]),   .layer6_out_V_data_9_V_TVALID(ov[9]),   .layer6_out_V_data_9_V_TREADY(tr[9]),
    .layer6_out_V_data_10_V_TDATA(od[10]), .layer6_out_V_data_10_V_TVALID(ov[10]), .layer6_out_V_data_10_V_TREADY(tr[10]),
    .layer6_out_V_data_11_V_TDATA(od[11]), .layer6_out_V_data_11_V_TVALID(ov[11]), .layer6_out_V_data_11_V_TREADY(tr[11]),
    .layer6_out_V_data_12_V_TDATA(od[12]), .layer6_out_V_data_12_V_TVALID(ov[12]), .layer6_out_V_data_12_V_TREADY(tr[12]),
    .layer6_out_V_data_13_V_TDATA(od[13]), .layer6_out_V_data_13_V_TVALID(ov[13]), .layer6_out_V_data_13_V_TREADY(tr[13]),
    .layer6_out_V_data_14_V_TDATA(od[14]), .layer6_out_V_data_14_V_TVALID(ov[14]), .layer6_out_V_data_14_V_TREADY(tr[14]),
    .layer6_out_V_data_15_V_TDATA(od[15]), .layer6_out_V_data_15_V_TVALID(ov[15]), .layer6_out_V_data_15_V_TREADY(tr[15]),
    .const_size_in_1(sz_in), .const_size_in_1_ap_vld(sz_in_v),
    .const_size_out_1(sz_out), .const_size_out_1_ap_vld(sz_out_v)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [15:0] vld_vec();
    logic [15:0] v;
    for (int k = 0; k < 16; k++) v[k] = ov[k];
    return v;
  endfunction

  // Identity weights on 0..7, bias 256*k, wrap to 16 bits, then ReLU.
  function automatic logic [15:0] ref_y(input logic signed [15:0] x, input int k);
    int r;
    logic signed [15:0] r16;
    r   = (k < 8 ? int'(x) : 0) + 256 * k;
    r16 = r[15:0];
    return (r16 < 0) ? 16'd0 : r16;
  endfunction

  task automatic run_inf(input logic signed [15:0] xs [8], input bit stall);
    logic [15:0] exp_y [16];
    for (int k = 0; k < 16; k++) exp_y[k] = ref_y(xs[k % 8], k);
    @(negedge clk);
    chk("idle_pre", {31'd0, idle}, 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("size_in_vld",  {31'd0, sz_in_v},  32'd1);
    chk("size_out_vld", {31'd0, sz_out_v}, 32'd1);
    chk("size_in",  {16'd0, sz_in},  32'd8);
    chk("size_out", {16'd0, sz_out}, 32'd16);
    chk("tready_load", {31'd0, in_r}, 32'd1);
    chk("idle_load",   {31'd0, idle}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      in_d = xs[i];
      in_v = 1'b1;
      @(negedge clk);
      chk($sformatf("ready_beat%0d", i), {31'd0, ready}, {31'd0, (i == 7)});
    end
    in_v = 1'b0;
    chk("tready_final", {31'd0, in_r}, 32'd0);
    chk("vld_final", {16'd0, vld_vec()}, 32'd0);
    tr = stall ? 16'hFC00 : 16'hFFFF;
    @(negedge clk);
    chk("ready_clr", {31'd0, ready}, 32'd0);
    chk("vld_all", {16'd0, vld_vec()}, 32'h0000FFFF);
    for (int k = 0; k < 16; k++) begin
      last_y[k] = od[k];
      chk($sformatf("y%0d", k), {16'd0, od[k]}, {16'd0, exp_y[k]});
    end
    if (stall) begin
      @(negedge clk);
      chk("vld_partial", {16'd0, vld_vec()}, 32'h000003FF);
      chk("done_early", {31'd0, done}, 32'd0);
      for (int k = 0; k < 10; k++)
        chk($sformatf("hold_y%0d", k), {16'd0, od[k]}, {16'd0, exp_y[k]});
      tr = 16'hFFFF;
    end
    @(negedge clk);
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("vld_none", {16'd0, vld_vec()}, 32'd0);
    chk("idle_done", {31'd0, idle}, 32'd1);
    @(negedge clk);
    chk("done_clr", {31'd0, done}, 32'd0);
  endtask

  task automatic check_s2_hand();
    chk("s2_y0",  {16'd0, last_y[0]},  32'd9999);
    chk("s2_y1",  {16'd0, last_y[1]},  32'd10255);
    chk("s2_y7",  {16'd0, last_y[7]},  32'd11791);
    chk("s2_y8",  {16'd0, last_y[8]},  32'd2048);
    chk("s2_y15", {16'd0, last_y[15]}, 32'd3840);
  endtask

  initial begin
    logic signed [15:0] xs [8];
    rst_n = 1'b0; start = 1'b0; in_d = '0; in_v = 1'b0; tr = 16'hFFFF;
    repeat (3) @(negedge clk);
    chk("rst_idle",  {31'd0, idle},  32'd1);
    chk("rst_vld",   {16'd0, vld_vec()}, 32'd0);
    chk("rst_done",  {31'd0, done},  32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_szvld", {30'd0, sz_in_v, sz_out_v}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {31'd0, idle}, 32'd1);

    for (int i = 0; i < 8; i++) xs[i] = 16'sd9999;
    run_inf(xs, 1'b0);
    check_s2_hand();

    for (int i = 0; i < 8; i++) xs[i] = 16'sd0;
    xs[0] = -16'sd1024;
    run_inf(xs, 1'b0);
    chk("s3_y0_relu", {16'd0, last_y[0]}, 32'd0);
    chk("s3_y1",      {16'd0, last_y[1]}, 32'd256);

    for (int i = 0; i < 8; i++) xs[i] = 16'sd0;
    xs[7] = 16'sh7FFF;
    run_inf(xs, 1'b0);
    chk("s4_y7_wrap", {16'd0, last_y[7]}, 32'd0);

    for (int i = 0; i < 8; i++) xs[i] = 16'sd100 * 16'(i + 1);
    run_inf(xs, 1'b1);

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_v  = 1'b1;
    in_d  = 16'd500;
    repeat (3) @(negedge clk);
    chk("mid_tready", {31'd0, in_r}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_idle",   {31'd0, idle}, 32'd1);
    chk("abort_tready", {31'd0, in_r}, 32'd0);
    in_v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_vld", {16'd0, vld_vec()}, 32'd0);
    for (int i = 0; i < 8; i++) xs[i] = 16'sd9999;
    run_inf(xs, 1'b0);
    check_s2_hand();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/nn_stream_dense16.md
Name: nn_stream_dense16

Overview:
- Streaming fixed-point inference core for the neutron-detector network, packaged as an HLS-style block with ap_ctrl_hs control.
- Each run consumes N_IN scalar samples from one AXI-Stream input.
- Computes one dense layer (N_IN→16) with bias and ReLU.
- Emits 16 results on 16 parallel AXI-Stream output channels.
- Sits between the detector sample front end and downstream classification logic.

Parameters:
- N_IN, 8, input samples consumed per inference.
- N_OUT, 16, output channels; fixed, structurally tied to the port list.
- DW, 16, data width; ap_fixed<16,6> (signed, 10 fractional bits).

Ports:
- ap_clk  in  1  clock.
- ap_rst_n  in  1  reset.
- ap_start  in  1  start request.
- ap_done  out  1  one-cycle pulse when all 16 outputs have been delivered.
- ap_idle  out  1  high while no run is in progress.
- ap_ready  out  1  one-cycle pulse when the last input sample is accepted.
- input_1_V_data_0_V_TDATA  in  16  input sample, Q6.10 signed.
- input_1_V_data_0_V_TVALID  in  1  input valid.
- input_1_V_data_0_V_TREADY  out  1  input ready.
- layer6_out_V_data_k_V_TDATA  out  16  result k, for k=0..15, Q6.10.
- layer6_out_V_data_k_V_TVALID  out  1  result k valid.
- layer6_out_V_data_k_V_TREADY  in  1  result k ready.
- const_size_in_1  out  16  constant N_IN.
- const_size_in_1_ap_vld  out  1  qualifier for const_size_in_1.
- const_size_out_1  out  16  constant N_OUT.
- const_size_out_1_ap_vld  out  1  qualifier for const_size_out_1.

Behaviour:
- Clock and reset: one clock, ap_clk, rising edge. Reset ap_rst_n is asynchronous and active-low.
- Reset values: all registered outputs 0; state IDLE, so ap_idle=1. The const_size data ports always drive their constants; only their _ap_vld flags are registered.
- FSM states and transitions:
  - IDLE: ap_idle=1. If ap_start=1, go to LOAD, clear the 16 accumulators and sample counter, and pulse both const_size_*_ap_vld for 1 cycle.
  - LOAD: input TREADY=1. Each cycle with TVALID&TREADY:
    - acc[k] += x*W[cnt][k] for all k in parallel, using 16 signed 16x16 multipliers and 32-bit products.
    - Accumulators are 36 bits with 20 fractional bits.
    - cnt increments.
    - On the beat with cnt==N_IN-1, pulse ap_ready and go to FINAL.
    - A TVALID gap stalls without state change.
  - FINAL (1 cycle):
    - r[k] = acc[k] + (B[k] sign-extended, shifted left 10).
    - Take bits [25:10]: truncation toward -inf, wrap on overflow.
    - y[k] = r[k] < 0 ? 0 : r[k].
    - Register y into the output TDATA, set all 16 TVALID=1, go to OUT.
  - OUT:
    - Each channel drops its own TVALID after its own TVALID&TREADY handshake; channels are independent.
    - TDATA is held stable while TVALID=1.
    - When the last channel completes, pulse ap_done for 1 cycle and go to IDLE.
- Handshake rules:
  - ap_start is only sampled in IDLE. Holding it high starts the next run on the cycle after ap_done.
  - Input TREADY=0 outside LOAD.
- Latency:
  - Last input accepted → outputs valid 2 cycles later.
  - With all TREADY=1, ap_done follows 1 cycle after that.
- Reset mid-run: abort immediately to IDLE; partial results are discarded.
- Multiple-run throughput is not pipelined: one run at a time.

Decomposition:
- Package nn_stream_pkg holds:
  - N_IN, N_OUT, DW, FRAC=10 and the typedef fixed16_t.
  - Weight array W[N_IN][N_OUT] and bias array B[N_OUT].
- Default test coefficients:
  - W[i][k] = 1.0 (raw 1024) when k==i, else 0.
  - B[k] = raw 256*k.
  - Trained coefficients replace these defaults.
- One sub-module, nn_mac_lane, instantiated 16×: one multiply-accumulate, bias, truncate/wrap and ReLU lane.

Test Plan:
1. Reset, then release → ap_idle=1, all TVALID=0, ap_done=ap_ready=0.
2. ap_start=1; 8 samples of 9999, TVALID held high; all TREADY=1:
   - ap_ready pulses on the 8th accept.
   - y0=9999, y1=10255, y7=11791, y8=2048, y15=3840.
   - ap_done follows; const_size_in_1=8 and const_size_out_1=16 with vld pulses at start.
3. Sample 0 = -1024 (-1.0), others 0 → y0=0 (ReLU clamp), y1=256.
4. Sample 7 = 0x7FFF → r7 wraps to -30977 → y7=0.
5. Outputs 0..9 with TREADY=0 for 1 cycle after valid:
   - Channels 10..15 complete first.
   - Channels 0..9 keep data stable and complete the following cycle.
   - ap_done pulses exactly once, after the last channel.
6. Deassert ap_rst_n during LOAD after 3 samples → immediate IDLE. The next full run produces the scenario-2 values.
